// File: rtl/sdram_mem_arbiter_if.sv
// rtl/sdram_mem_arbiter_if.sv - IF/DM request ports and Avalon-MM command bus of the SDRAM arbiter
//
// Purpose: bundles the fetch port (if_*), the data port (dm_*) and the
// single-beat Avalon-MM master command/response signals (avm_*).
// Modports:
//   slave  - arbiter view: takes if_*/dm_* requests, drives their ready and
//            read-data returns, drives avm_* commands, takes bridge responses.
//   master - environment view (CPU ports plus bridge slave), the mirror image.
interface sdram_mem_arbiter_if #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 32
);
  // Fetch port (read only)
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_ready;
  logic [DATA_W-1:0]     if_rdata;
  logic                  if_rvalid;
  // Data port (read/write)
  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic [DATA_W/8-1:0]   dm_be;
  logic                  dm_ready;
  logic [DATA_W-1:0]     dm_rdata;
  logic                  dm_rvalid;
  // Avalon-MM master towards the bridge slave
  logic [ADDR_W-1:0]     avm_address;
  logic                  avm_read;
  logic                  avm_write;
  logic [DATA_W-1:0]     avm_writedata;
  logic [DATA_W/8-1:0]   avm_byteenable;
  logic                  avm_burstcount;
  logic                  avm_debugaccess;
  logic                  avm_waitrequest;
  logic [DATA_W-1:0]     avm_readdata;
  logic                  avm_readdatavalid;

  modport slave (
    input  if_req, if_addr,
    output if_ready, if_rdata, if_rvalid,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output dm_ready, dm_rdata, dm_rvalid,
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    output avm_burstcount, avm_debugaccess,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport master (
    output if_req, if_addr,
    input  if_ready, if_rdata, if_rvalid,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  dm_ready, dm_rdata, dm_rvalid,
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  avm_burstcount, avm_debugaccess,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );
endinterface

// File: rtl/sdram_mem_arbiter.sv
// rtl/sdram_mem_arbiter.sv - round-robin IF/DM arbiter issuing single-beat Avalon-MM commands
//
// Purpose: grants fetch and data requests round-robin into a one-entry
// Avalon-MM command slot and routes in-order read responses back to the
// issuing port through a tag FIFO of MAX_PENDING entries.
// Ports:
//   clk_clk          system clock
//   reset_reset_n    asynchronous active-low reset
//   bus (slave)      if_* fetch port, dm_* data port, avm_* bridge master
//   err_unexpected   sticky: readdatavalid seen with no read outstanding
module sdram_mem_arbiter #(
  parameter int ADDR_W      = 27,
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 4
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  sdram_mem_arbiter_if.slave bus,
  output logic               err_unexpected
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(MAX_PENDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic TAG_IF = 1'b0;
  localparam logic TAG_DM = 1'b1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } slot_state_t;

  slot_state_t          r_state;
  slot_state_t          w_state_next;

  logic [ADDR_W-1:0]    r_address;
  logic                 r_read;
  logic                 r_write;
  logic [DATA_W-1:0]    r_writedata;
  logic [BE_W-1:0]      r_byteenable;
  logic                 r_last_grant;

  logic [MAX_PENDING-1:0] r_tags;
  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic [CNT_W-1:0]     r_count;

  logic [DATA_W-1:0]    r_if_rdata;
  logic [DATA_W-1:0]    r_dm_rdata;
  logic                 r_if_rvalid;
  logic                 r_dm_rvalid;
  logic                 r_err;

  logic                 w_slot_free;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_count_ok;
  logic                 w_if_elig;
  logic                 w_dm_elig;
  logic                 w_grant_if;
  logic                 w_grant_dm;
  logic                 w_grant;
  logic                 w_head_tag;

  always_comb begin
    w_state_next = r_state;
    // The slot can take a new command when empty or when the held command
    // is being accepted by the bridge this very cycle.
    w_slot_free  = (r_state == S_IDLE) || !bus.avm_waitrequest;
    w_pop        = bus.avm_readdatavalid && (r_count != '0);
    w_head_tag   = r_tags[r_rptr];
    // A pop in the same cycle frees a tag entry for a read being granted.
    w_count_ok   = (r_count < CNT_W'(MAX_PENDING)) || w_pop;
    w_if_elig    = bus.if_req && w_slot_free && w_count_ok;
    w_dm_elig    = bus.dm_req && w_slot_free && (bus.dm_we || w_count_ok);
    // On contention the port that did not win last time gets the slot.
    w_grant_dm   = w_dm_elig && (!w_if_elig || (r_last_grant == TAG_IF));
    w_grant_if   = w_if_elig && !w_grant_dm;
    w_grant      = w_grant_if || w_grant_dm;
    w_push       = w_grant_if || (w_grant_dm && !bus.dm_we);

    if (w_grant) begin
      w_state_next = S_BUSY;
    end else if (w_slot_free) begin
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Command slot fields hold while the bridge asserts waitrequest.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_address    <= '0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_writedata  <= '0;
      r_byteenable <= '0;
      r_last_grant <= TAG_IF;
    end else if (w_grant) begin
      r_read       <= w_grant_if || !bus.dm_we;
      r_write      <= w_grant_dm && bus.dm_we;
      r_address    <= w_grant_dm ? bus.dm_addr : bus.if_addr;
      r_writedata  <= w_grant_dm ? bus.dm_wdata : '0;
      r_byteenable <= w_grant_dm ? bus.dm_be : '1;
      r_last_grant <= w_grant_dm ? TAG_DM : TAG_IF;
    end else if (w_slot_free) begin
      r_read  <= 1'b0;
      r_write <= 1'b0;
    end
  end

  // Tag FIFO: one bit per outstanding read naming the port it returns to.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_tags  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tags[r_wptr] <= w_grant_dm ? TAG_DM : TAG_IF;
        r_wptr         <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Response routing; the port not addressed keeps its last read data.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_if_rvalid <= w_pop && (w_head_tag == TAG_IF);
      r_dm_rvalid <= w_pop && (w_head_tag == TAG_DM);
      if (w_pop && (w_head_tag == TAG_IF)) begin
        r_if_rdata <= bus.avm_readdata;
      end
      if (w_pop && (w_head_tag == TAG_DM)) begin
        r_dm_rdata <= bus.avm_readdata;
      end
      if (bus.avm_readdatavalid && (r_count == '0)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.if_ready        = w_grant_if;
  assign bus.dm_ready        = w_grant_dm;
  assign bus.if_rdata        = r_if_rdata;
  assign bus.if_rvalid       = r_if_rvalid;
  assign bus.dm_rdata        = r_dm_rdata;
  assign bus.dm_rvalid       = r_dm_rvalid;
  assign bus.avm_address     = r_address;
  assign bus.avm_read        = r_read;
  assign bus.avm_write       = r_write;
  assign bus.avm_writedata   = r_writedata;
  assign bus.avm_byteenable  = r_byteenable;
  assign bus.avm_burstcount  = 1'b1;
  assign bus.avm_debugaccess = 1'b0;
  assign err_unexpected      = r_err;

endmodule

// File: tb/tb_sdram_mem_arbiter.sv
// tb/tb_sdram_mem_arbiter.sv - scoreboard bench for sdram_mem_arbiter
module tb_sdram_mem_arbiter;
  localparam int ADDR_W = 27;
  localparam int DATA_W = 32;
  localparam int MAXP   = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic err;

  always #5 clk = ~clk;

  sdram_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sdram_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(MAXP)) dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .bus            (bus),
    .err_unexpected (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [3:0]        be;
  } cmd_t;

  typedef struct packed {
    logic              port;   // 0 = IF, 1 = DM
    logic [DATA_W-1:0] data;
  } rsp_t;

  cmd_t cmd_q[$];   // commands expected on the Avalon bus, in order
  bit   tag_q[$];   // ports of reads granted and not yet answered
  rsp_t rsp_q[$];   // responses expected on the ports next cycle
  bit   m_last;     // port granted most recently
  bit   exp_err;

  always @(negedge clk) begin : monitor
    cmd_t c;
    rsp_t r;
    bit   t, slot_free, pop_now, cnt_ok, e_if, e_dm, g_if, g_dm;
    if (!rst_n) begin
      cmd_q.delete();
      tag_q.delete();
      rsp_q.delete();
      m_last  = 1'b0;
      exp_err = 1'b0;
    end else begin
      check("err_unexpected", err, exp_err);
      check("avm_burstcount", bus.avm_burstcount, 1);
      check("avm_debugaccess", bus.avm_debugaccess, 0);

      // responses from readdatavalid seen one cycle ago
      if (bus.if_rvalid || bus.dm_rvalid) begin
        if (rsp_q.size() == 0) begin
          check("rvalid_spurious", {bus.if_rvalid, bus.dm_rvalid}, 2'b00);
        end else begin
          r = rsp_q.pop_front();
          check("rvalid_port", {bus.if_rvalid, bus.dm_rvalid}, r.port ? 2'b01 : 2'b10);
          check("rdata", r.port ? bus.dm_rdata : bus.if_rdata, r.data);
        end
      end else if (rsp_q.size() != 0) begin
        r = rsp_q.pop_front();
        check("rvalid_missing", 0, 1);
      end

      // command slot contents
      slot_free = (cmd_q.size() == 0) || !bus.avm_waitrequest;
      if (cmd_q.size() == 0) begin
        check("avm_idle", {bus.avm_read, bus.avm_write}, 2'b00);
      end else begin
        c = cmd_q[0];
        check("avm_rw", {bus.avm_read, bus.avm_write}, c.we ? 2'b01 : 2'b10);
        check("avm_address", bus.avm_address, c.addr);
        check("avm_byteenable", bus.avm_byteenable, c.be);
        if (c.we) check("avm_writedata", bus.avm_writedata, c.data);
        if (!bus.avm_waitrequest) c = cmd_q.pop_front();
      end

      // read data return and tag occupancy
      pop_now = bus.avm_readdatavalid && (tag_q.size() > 0);
      cnt_ok  = (tag_q.size() < MAXP) || pop_now;
      if (bus.avm_readdatavalid) begin
        if (pop_now) begin
          t = tag_q.pop_front();
          r.port = t;
          r.data = bus.avm_readdata;
          rsp_q.push_back(r);
        end else begin
          exp_err = 1'b1;
        end
      end

      // round-robin grant
      e_if = bus.if_req && slot_free && cnt_ok;
      e_dm = bus.dm_req && slot_free && (bus.dm_we || cnt_ok);
      g_dm = e_dm && (!e_if || !m_last);
      g_if = e_if && !g_dm;
      check("if_ready", bus.if_ready, g_if);
      check("dm_ready", bus.dm_ready, g_dm);
      if (g_if) begin
        c.we = 1'b0; c.addr = bus.if_addr; c.data = '0; c.be = 4'hF;
        cmd_q.push_back(c);
        tag_q.push_back(1'b0);
        m_last = 1'b0;
      end else if (g_dm) begin
        c.we = bus.dm_we; c.addr = bus.dm_addr; c.data = bus.dm_wdata; c.be = bus.dm_be;
        cmd_q.push_back(c);
        if (!bus.dm_we) tag_q.push_back(1'b1);
        m_last = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  bit hs_if, hs_dm;
  int slv_pend;   // reads accepted by the bridge model and not yet answered
  bit order_q[$];
  logic [31:0] rnd;

  task automatic cyc();
    @(negedge clk);
    hs_if = bus.if_req && bus.if_ready;
    hs_dm = bus.dm_req && bus.dm_ready;
    if (bus.avm_read && !bus.avm_waitrequest) slv_pend++;
    if (bus.avm_readdatavalid && slv_pend > 0) slv_pend--;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input bit dm);
    int k = 0;
    do begin
      cyc();
      k++;
    end while (!(dm ? hs_dm : hs_if) && k < 40);
    check(dm ? "dm_handshake_timeout" : "if_handshake_timeout", dm ? hs_dm : hs_if, 1);
  endtask

  task automatic respond(input logic [31:0] d);
    bus.avm_readdata      = d;
    bus.avm_readdatavalid = 1'b1;
    cyc();
    bus.avm_readdatavalid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.if_req = 0; bus.if_addr = '0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0; bus.dm_be = '0;
    bus.avm_waitrequest = 0; bus.avm_readdata = '0; bus.avm_readdatavalid = 0;
    slv_pend = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_avm_read", bus.avm_read, 0);
    check("rst_avm_write", bus.avm_write, 0);
    check("rst_avm_address", bus.avm_address, 0);
    check("rst_avm_byteenable", bus.avm_byteenable, 0);
    check("rst_avm_burstcount", bus.avm_burstcount, 1);
    check("rst_rvalid", {bus.if_rvalid, bus.dm_rvalid}, 0);
    check("rst_rdata", {bus.if_rdata, bus.dm_rdata}, 0);
    check("rst_ready", {bus.if_ready, bus.dm_ready}, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    cyc();

    // single IF read, response three cycles after the command
    bus.if_addr = 27'h0000100;
    bus.if_req  = 1'b1;
    wait_hs(1'b0);
    bus.if_req = 1'b0;
    cyc(); cyc();
    respond(32'hDEADBEEF);
    cyc(); cyc();
    check("t1_if_rdata", bus.if_rdata, 32'hDEADBEEF);

    // both ports held with reads: grants alternate starting with DM
    bus.if_addr = 27'h0000200; bus.if_req = 1'b1;
    bus.dm_addr = 27'h0000300; bus.dm_we = 1'b0; bus.dm_be = 4'hC; bus.dm_req = 1'b1;
    for (int k = 0; k < 20 && order_q.size() < 4; k++) begin
      cyc();
      if (hs_if || hs_dm) order_q.push_back(hs_dm);
    end
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    check("t2_grant_count", order_q.size(), 4);
    for (int i = 0; i < order_q.size(); i++) check("t2_grant_order", order_q[i], (i % 2) == 0);
    for (int i = 0; i < 4; i++) respond($urandom);
    cyc(); cyc();

    // DM write held by waitrequest for five cycles
    bus.dm_we = 1'b1; bus.dm_addr = 27'h0000040; bus.dm_wdata = 32'h12345678; bus.dm_be = 4'h3;
    bus.dm_req = 1'b1;
    wait_hs(1'b1);
    bus.dm_req = 1'b0;
    bus.avm_waitrequest = 1'b1;
    repeat (5) cyc();
    bus.avm_waitrequest = 1'b0;
    cyc(); cyc();

    // tag FIFO full: reads stall, writes still pass, a pop frees a read at once
    for (int i = 0; i < MAXP; i++) begin
      bus.if_addr = 27'(i * 4);
      bus.if_req  = 1'b1;
      wait_hs(1'b0);
      bus.if_req = 1'b0;
    end
    bus.if_addr = 27'h0000500; bus.if_req = 1'b1;
    bus.dm_we = 1'b1; bus.dm_addr = 27'h0000600; bus.dm_wdata = 32'hA5A5A5A5; bus.dm_be = 4'hF;
    bus.dm_req = 1'b1;
    cyc();
    check("t4_read_blocked", hs_if, 0);
    check("t4_write_granted", hs_dm, 1);
    bus.dm_req = 1'b0;
    cyc();
    check("t4_read_still_blocked", hs_if, 0);
    respond(32'h11110000);
    check("t4_read_on_pop", hs_if, 1);
    bus.if_req = 1'b0;
    for (int i = 0; i < MAXP; i++) respond($urandom);
    cyc(); cyc();
    slv_pend = 0;

    // randomized traffic against the scoreboard
    for (int n = 0; n < 3000; n++) begin
      if (!bus.if_req || hs_if) begin
        rnd = $urandom; bus.if_addr = rnd[ADDR_W-1:0];
        bus.if_req = ($urandom % 3) != 0;
      end
      if (!bus.dm_req || hs_dm) begin
        rnd = $urandom; bus.dm_addr = rnd[ADDR_W-1:0];
        bus.dm_wdata = $urandom;
        rnd = $urandom; bus.dm_be = rnd[3:0];
        bus.dm_we  = $urandom_range(0, 1) == 1;
        bus.dm_req = ($urandom % 3) != 0;
      end
      bus.avm_waitrequest   = ($urandom % 4) == 0;
      bus.avm_readdatavalid = (slv_pend > 0) && ($urandom_range(0, 1) == 1);
      bus.avm_readdata      = $urandom;
      cyc();
    end
    bus.if_req = 1'b0; bus.dm_req = 1'b0; bus.avm_waitrequest = 1'b0;
    bus.avm_readdatavalid = 1'b0;
    cyc(); cyc(); cyc();
    for (int k = 0; k < 100 && slv_pend > 0; k++) begin
      bus.avm_readdata = $urandom;
      bus.avm_readdatavalid = 1'b1;
      cyc();
    end
    bus.avm_readdatavalid = 1'b0;
    check("drain_reads", slv_pend, 0);
    cyc(); cyc();

    // reset with two reads outstanding and the slot held by waitrequest
    bus.if_addr = 27'h0000700; bus.if_req = 1'b1;
    bus.dm_addr = 27'h0000710; bus.dm_we = 1'b0; bus.dm_req = 1'b1;
    order_q.delete();
    for (int k = 0; k < 20 && order_q.size() < 2; k++) begin
      cyc();
      if (hs_if || hs_dm) order_q.push_back(hs_dm);
    end
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    bus.avm_waitrequest = 1'b1;
    check("t6_two_grants", order_q.size(), 2);
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_avm_read", bus.avm_read, 0);
    check("t6_rst_avm_write", bus.avm_write, 0);
    cyc();
    rst_n = 1'b1;
    bus.avm_waitrequest = 1'b0;
    slv_pend = 0;
    cyc();
    respond(32'hBAD0BAD0);   // late response of a discarded read
    cyc();
    check("t6_err_set", err, 1);
    bus.if_addr = 27'h0000100; bus.if_req = 1'b1;
    wait_hs(1'b0);
    bus.if_req = 1'b0;
    cyc();
    respond(32'hCAFEF00D);
    cyc(); cyc();
    check("t6_if_rdata", bus.if_rdata, 32'hCAFEF00D);
    check("t6_err_sticky", err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
